// File: rtl/controlador_io.sv
// controlador_io: IN/OUT responder. Stalls the datapath on IN until a debounced button confirms the switches; latches OUT onto the display.
// Build option: define IO_ECHO_EN to also echo each captured switch value onto the display.
module controlador_io #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned SW_W         = 16,
  parameter int unsigned DEBOUNCE_CYC = 4,
  parameter int unsigned CNT_W        = 20
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              op_in,
  input  logic              op_out,
  input  logic [DATA_W-1:0] out_data,
  input  logic [SW_W-1:0]   switches,
  input  logic              btn_confirm,
  output logic              stall,
  output logic [DATA_W-1:0] in_data,
  output logic              in_valid,
  output logic [DATA_W-1:0] display,
  output logic              waiting
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_PRESS,
    DONE,
    WAIT_RELEASE
  } state_t;

  state_t            state_q, state_d;
  logic              sync1_q, sync1_d;
  logic              btn_s_q, btn_s_d;
  logic              deb_q, deb_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] in_data_q, in_data_d;
  logic [DATA_W-1:0] display_q, display_d;
  logic              in_valid_q, in_valid_d;
  logic              waiting_q, waiting_d;
  logic              deb_rise, deb_fall;

  // Button synchronizer and debouncer: a run of DEBOUNCE_CYC opposite samples flips the level.
  always_comb begin
    sync1_d = btn_confirm;
    btn_s_d = sync1_q;
    deb_d   = deb_q;
    cnt_d   = '0;
    if (btn_s_q != deb_q) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_d == CNT_MAX) begin
        deb_d = ~deb_q;
        cnt_d = '0;
      end
    end
  end

  assign deb_rise = deb_d & ~deb_q;
  assign deb_fall = ~deb_d & deb_q;

  // Control sequencing for IN, plus OUT servicing while no IN is outstanding.
  always_comb begin
    state_d   = state_q;
    in_data_d = in_data_q;
    display_d = display_q;
    case (state_q)
      IDLE: begin
        if (op_in) begin
          state_d = WAIT_PRESS;
        end else if (op_out) begin
          display_d = out_data;
        end
      end
      WAIT_PRESS: begin
        if (deb_rise) begin
          in_data_d = DATA_W'(switches);
`ifdef IO_ECHO_EN
          display_d = DATA_W'(switches);
`endif
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        // A new IN must wait for the release so a held button cannot confirm it.
        if (deb_fall) begin
          state_d = IDLE;
        end
        if (op_out && !op_in) begin
          display_d = out_data;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    in_valid_d = (state_d == DONE);
    waiting_d  = (state_d == WAIT_PRESS);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      sync1_q    <= 1'b0;
      btn_s_q    <= 1'b0;
      deb_q      <= 1'b0;
      cnt_q      <= '0;
      in_data_q  <= '0;
      display_q  <= '0;
      in_valid_q <= 1'b0;
      waiting_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      btn_s_q    <= btn_s_d;
      deb_q      <= deb_d;
      cnt_q      <= cnt_d;
      in_data_q  <= in_data_d;
      display_q  <= display_d;
      in_valid_q <= in_valid_d;
      waiting_q  <= waiting_d;
    end
  end

  // Stall must answer op_in in the same cycle, so it stays combinational.
  assign stall = ~reset & ((op_in & ((state_q == IDLE) | (state_q == WAIT_RELEASE)))
                           | (state_q == WAIT_PRESS));

  assign in_data  = in_data_q;
  assign in_valid = in_valid_q;
  assign display  = display_q;
  assign waiting  = waiting_q;

endmodule

// File: tb/tb_controlador_io.sv
// tb_controlador_io: directed scenarios plus random traffic against a behavioural model of controlador_io.
module tb_controlador_io;

  localparam int DEB = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        op_in;
  logic        op_out;
  logic [31:0] out_data;
  logic [15:0] switches;
  logic        btn_confirm;
  logic        stall;
  logic [31:0] in_data;
  logic        in_valid;
  logic [31:0] display;
  logic        waiting;

  controlador_io #(
    .DATA_W(32), .SW_W(16), .DEBOUNCE_CYC(DEB), .CNT_W(20)
  ) dut (
    .clock(clock), .reset(reset), .op_in(op_in), .op_out(op_out),
    .out_data(out_data), .switches(switches), .btn_confirm(btn_confirm),
    .stall(stall), .in_data(in_data), .in_valid(in_valid),
    .display(display), .waiting(waiting)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_valid  = 0;
  int valid_cyc = 0;

  // Behavioural model: raw button history, debounced level, and IN bookkeeping flags.
  int          hist[$];
  bit          m_deb, m_wpress, m_valid, m_wrel;
  logic [31:0] m_in_data, m_display;

  bit bounce_pat [8] = '{1, 1, 1, 0, 1, 1, 1, 1};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // The level flips when the last DEB synchronized samples (raw delayed by two edges) all disagree with it.
  function automatic bit deb_flips();
    int n = hist.size();
    if (n < DEB + 1) return 1'b0;
    for (int i = 0; i < DEB; i++) begin
      if ((hist[n - 2 - i] != 0) == m_deb) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic bit exp_stall();
    bit idle = !m_wpress && !m_valid && !m_wrel;
    return !reset && ((idle && op_in) || m_wpress || (m_wrel && op_in));
  endfunction

  task automatic model_step();
    bit flip, rise, fall;
    if (reset) begin
      hist.delete();
      hist.push_back(0);
      hist.push_back(0);
      m_deb = 0; m_wpress = 0; m_valid = 0; m_wrel = 0;
      m_in_data = '0; m_display = '0;
      return;
    end
    flip = deb_flips();
    rise = flip && !m_deb;
    fall = flip && m_deb;
    if (flip) m_deb = !m_deb;
    hist.push_back(int'(btn_confirm));
    if (hist.size() > DEB + 2) void'(hist.pop_front());
    if (m_wpress) begin
      if (rise) begin
        m_in_data = {16'h0000, switches};
`ifdef IO_ECHO_EN
        m_display = {16'h0000, switches};
`endif
        m_valid   = 1;
        m_wpress  = 0;
      end
    end else if (m_valid) begin
      m_valid = 0;
      m_wrel  = 1;
    end else if (m_wrel) begin
      if (fall) m_wrel = 0;
      if (op_out && !op_in) m_display = out_data;
    end else begin
      if (op_in) m_wpress = 1;
      else if (op_out) m_display = out_data;
    end
  endtask

  // One clock: drive on the falling edge, check outputs, then advance the model at the rising edge.
  task automatic cycle(input bit rst, input bit oi, input bit oo, input logic [31:0] od,
                       input logic [15:0] sw, input bit b);
    @(negedge clock);
    cyc++;
    reset = rst; op_in = oi; op_out = oo; out_data = od; switches = sw; btn_confirm = b;
    #1;
    check_eq("stall", 64'(stall), 64'(exp_stall()));
    check_eq("waiting", 64'(waiting), 64'(m_wpress));
    check_eq("in_valid", 64'(in_valid), 64'(m_valid));
    check_eq("in_data", 64'(in_data), 64'(m_in_data));
    check_eq("display", 64'(display), 64'(m_display));
    if (in_valid === 1'b1) begin
      n_valid++;
      valid_cyc = cyc;
    end
    @(posedge clock);
    model_step();
  endtask

  int v0, v1, press_cyc, hold;
  bit act, tgt, rb, oo_r, b_r;

  initial begin
    reset = 1'b1; op_in = 1'b0; op_out = 1'b0; out_data = '0; switches = '0; btn_confirm = 1'b0;
    @(posedge clock);
    model_step();

    // Reset state
    cycle(1, 0, 0, 0, 16'h0, 0);
    cycle(1, 0, 0, 0, 16'h0, 0);
    #1;
    check_eq("rst_display", 64'(display), 64'h0);
    check_eq("rst_in_data", 64'(in_data), 64'h0);
    check_eq("rst_in_valid", 64'(in_valid), 64'h0);
    check_eq("rst_waiting", 64'(waiting), 64'h0);
    cycle(0, 0, 0, 0, 16'h0, 0);
    check_eq("idle_stall", 64'(stall), 64'h0);

    // OUT
    cycle(0, 0, 1, 32'h0000_00A5, 16'h0, 0);
    #1;
    check_eq("out_display", 64'(display), 64'h0000_00A5);
    cycle(0, 0, 0, 0, 16'h0, 0);

    // Clean IN press
    v0 = n_valid;
    cycle(0, 1, 0, 0, 16'h1234, 0);
    cycle(0, 1, 0, 0, 16'h1234, 0);
    press_cyc = cyc + 1;
    for (int i = 0; i < 12; i++) cycle(0, n_valid == v0, 0, 0, 16'h1234, 1);
    check_eq("in_latency", 64'(valid_cyc - press_cyc), 64'(DEB + 2));
    check_eq("in_pulses", 64'(n_valid - v0), 64'd1);
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 16'h1234, 0);
    #1;
    check_eq("in_value", 64'(in_data), 64'h0000_1234);
`ifdef IO_ECHO_EN
    check_eq("in_echo", 64'(display), 64'h0000_1234);
`else
    check_eq("in_noecho", 64'(display), 64'h0000_00A5);
`endif

    // Bouncing press
    v0 = n_valid;
    cycle(0, 1, 0, 0, 16'h5A5A, 0);
    cycle(0, 1, 0, 0, 16'h5A5A, 0);
    press_cyc = cyc + 1;
    for (int i = 0; i < 8; i++) cycle(0, n_valid == v0, 0, 0, 16'h5A5A, bounce_pat[i]);
    for (int i = 0; i < 6; i++) cycle(0, n_valid == v0, 0, 0, 16'h5A5A, 1);
    check_eq("bounce_latency", 64'(valid_cyc - press_cyc), 64'd10);
    check_eq("bounce_pulses", 64'(n_valid - v0), 64'd1);
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 16'h5A5A, 0);

    // Held button across a second IN
    v0 = n_valid;
    cycle(0, 1, 0, 0, 16'hAAAA, 0);
    cycle(0, 1, 0, 0, 16'hAAAA, 0);
    for (int i = 0; i < 10; i++) cycle(0, n_valid == v0, 0, 0, 16'hAAAA, 1);
    cycle(0, 0, 0, 0, 16'h00FF, 1);
    for (int i = 0; i < 15; i++) cycle(0, 1, 0, 0, 16'h00FF, 1);
    #1;
    check_eq("held_stall", 64'(stall), 64'd1);
    check_eq("held_pulses", 64'(n_valid - v0), 64'd1);
    for (int i = 0; i < 10; i++) cycle(0, 1, 0, 0, 16'h00FF, 0);
    v1 = n_valid;
    for (int i = 0; i < 12; i++) cycle(0, n_valid == v1, 0, 0, 16'h00FF, 1);
    check_eq("held_new_pulse", 64'(n_valid - v1), 64'd1);
    #1;
    check_eq("held_value", 64'(in_data), 64'h0000_00FF);
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 16'h00FF, 0);

    // Reset in the middle of an IN
    v0 = n_valid;
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 16'h7777, 0);
    for (int i = 0; i < 2; i++) cycle(0, 1, 0, 0, 16'h7777, 1);
    cycle(1, 1, 0, 0, 16'h7777, 1);
    cycle(1, 1, 0, 0, 16'h7777, 1);
    #1;
    check_eq("mid_rst_stall", 64'(stall), 64'h0);
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, 16'h7777, 0);
    #1;
    check_eq("mid_rst_pulses", 64'(n_valid - v0), 64'h0);
    check_eq("mid_rst_in_data", 64'(in_data), 64'h0);
    check_eq("mid_rst_stall_after", 64'(stall), 64'h0);

    // Random traffic
    act = 0; tgt = 0; hold = 0;
    for (int i = 0; i < 3000; i++) begin
      rb = ($urandom_range(0, 299) == 0);
      if (hold == 0) begin
        tgt  = !tgt;
        hold = $urandom_range(10, 60);
      end
      hold--;
      b_r = ($urandom_range(0, 9) == 0) ? !tgt : tgt;
      if (!act && $urandom_range(0, 7) == 0) act = 1;
      oo_r = !act && ($urandom_range(0, 5) == 0);
      cycle(rb, act, oo_r, $urandom(), 16'($urandom()), b_r);
      if (m_valid || rb) act = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
